// File: rtl/aes_mode_pkg.sv
// Shared types and constants for the AES block-mode engine.
// Mode encodings, FSM states and round-count helper.
package aes_mode_pkg;

    localparam int AES_BLK = 128;

    localparam logic [1:0] MODE_ECB = 2'd0;
    localparam logic [1:0] MODE_CBC = 2'd1;
    localparam logic [1:0] MODE_CTR = 2'd2;
    localparam logic [1:0] MODE_OFB = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } state_t;

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

endpackage

// File: rtl/aes_mode_engine_core.sv
// Iterative AES encryption core: expands the key one word per cycle,
// then runs one cipher round per cycle. o_vld pulses for one cycle.
module AES_Encrypt #(
    parameter int KEY_BITS = 128,
    parameter int NR       = 10,
    parameter int NK       = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_vld,
    input  logic [127:0]        i_blk,
    input  logic [KEY_BITS-1:0] i_key,
    output logic [127:0]        o_blk,
    output logic                o_vld
);
    localparam int NW = 4 * (NR + 1);
    localparam logic [5:0] NK6  = 6'(NK);
    localparam logic [5:0] NWL  = 6'(NW - 1);
    localparam logic [3:0] NR4  = 4'(NR);
    localparam logic [3:0] NKM1 = 4'(NK - 1);

    localparam logic [2047:0] SBOX = {
        256'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {C_IDLE, C_KEXP, C_ROUND, C_DONE} cst_t;

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    // Byte k sits at row k%4, column k/4; ShiftRows pulls from column (c+r)%4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        int src;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            src = 4 * (((k / 4) + (k % 4)) % 4) + (k % 4);
            o[127-8*k -: 8] = sb(s[127-8*src -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {
                xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)
            };
        end
        return o;
    endfunction

    cst_t         r_cs, w_cn;
    logic [31:0]  r_w [NW];
    logic [127:0] r_s;
    logic [5:0]   r_wi;
    logic [3:0]   r_kc;
    logic [3:0]   r_rnd;
    logic [7:0]   r_rcon;
    logic [31:0]  w_prev, w_old, w_tmp, w_new;
    logic [5:0]   w_base;
    logic [127:0] w_sr, w_rk, w_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_cs <= C_IDLE;
        else       r_cs <= w_cn;
    end

    always_comb begin
        w_cn = r_cs;
        unique case (r_cs)
            C_IDLE:  if (i_vld) w_cn = C_KEXP;
            C_KEXP:  if (r_wi == NWL) w_cn = C_ROUND;
            C_ROUND: if (r_rnd == NR4) w_cn = C_DONE;
            C_DONE:  w_cn = C_IDLE;
            default: w_cn = C_IDLE;
        endcase
    end

    always_comb begin
        w_prev = r_w[r_wi - 6'd1];
        w_old  = r_w[r_wi - NK6];
        w_tmp  = w_prev;
        if (r_kc == 4'd0)
            w_tmp = subw({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
        else if (NK > 6 && r_kc == 4'd4)
            w_tmp = subw(w_prev);
        w_new  = w_old ^ w_tmp;
        w_base = {r_rnd, 2'b00};
        w_sr   = sub_shift(r_s);
        w_rk   = {r_w[w_base], r_w[w_base + 6'd1],
                  r_w[w_base + 6'd2], r_w[w_base + 6'd3]};
        w_nxt  = ((r_rnd == NR4) ? w_sr : mix(w_sr)) ^ w_rk;
    end

    always_ff @(posedge i_clk) begin
        if (r_cs == C_IDLE && i_vld) begin
            for (int j = 0; j < NK; j++)
                r_w[j] <= i_key[KEY_BITS-1-32*j -: 32];
            r_s    <= i_blk ^ i_key[KEY_BITS-1 -: 128];
            r_wi   <= NK6;
            r_kc   <= 4'd0;
            r_rcon <= 8'h01;
        end
        if (r_cs == C_KEXP) begin
            r_w[r_wi] <= w_new;
            r_wi      <= r_wi + 6'd1;
            r_kc      <= (r_kc == NKM1) ? 4'd0 : r_kc + 4'd1;
            if (r_kc == 4'd0) r_rcon <= xt(r_rcon);
            r_rnd     <= 4'd1;
        end
        if (r_cs == C_ROUND) begin
            r_s   <= w_nxt;
            r_rnd <= r_rnd + 4'd1;
        end
    end

    assign o_vld = (r_cs == C_DONE);
    assign o_blk = r_s;

endmodule

// File: rtl/aes_mode_engine.sv
// AES block-mode engine: ECB / CBC-encrypt / CTR / OFB around one
// iterative AES core, with valid/ready handshakes on both sides.
module aes_mode_engine
    import aes_mode_pkg::*;
#(
    parameter int KEY_BITS = 128,
    parameter int CTR_BITS = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_cfg_vld,
    input  logic [1:0]          i_mode,
    input  logic [KEY_BITS-1:0] i_key,
    input  logic [127:0]        i_iv,
    input  logic                i_vld,
    output logic                o_rdy,
    input  logic [127:0]        i_data,
    output logic                o_vld,
    input  logic                i_rdy,
    output logic [127:0]        o_data,
    output logic                o_busy
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = nr_of(KEY_BITS);

    state_t               r_state, w_next;
    logic                 r_cfg_ok;
    logic [1:0]           r_mode;
    logic [KEY_BITS-1:0]  r_key;
    logic [AES_BLK-1:0]   r_chain, r_data, r_core_in, r_odata;
    logic                 w_cfg, w_acc, w_done;
    logic                 w_core_ivld, w_core_vld, w_core_rst;
    logic [AES_BLK-1:0]   w_core_out, w_core_sel, w_result, w_chain_nx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_acc) w_next = ST_RUN;
            ST_RUN:  if (w_core_vld) w_next = ST_HOLD;
            ST_HOLD: if (i_rdy) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_rdy       = 1'b0;
        o_vld       = 1'b0;
        o_busy      = 1'b0;
        w_core_ivld = 1'b0;
        unique case (r_state)
            ST_IDLE: o_rdy = r_cfg_ok & ~i_cfg_vld;
            ST_RUN: begin
                o_busy      = 1'b1;
                w_core_ivld = 1'b1;
            end
            ST_HOLD: begin
                o_busy = 1'b1;
                o_vld  = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_cfg  = i_cfg_vld & (r_state == ST_IDLE);
    assign w_acc  = i_vld & o_rdy;
    assign w_done = w_core_ivld & w_core_vld;

    always_comb begin
        w_core_sel = r_chain;
        w_result   = w_core_out;
        w_chain_nx = r_chain;
        unique case (r_mode)
            MODE_ECB: w_core_sel = i_data;
            MODE_CBC: begin
                w_core_sel = i_data ^ r_chain;
                w_chain_nx = w_core_out;
            end
            MODE_CTR: begin
                w_result = w_core_out ^ r_data;
                w_chain_nx[CTR_BITS-1:0] = r_chain[CTR_BITS-1:0] + CTR_BITS'(1);
            end
            MODE_OFB: begin
                w_result   = w_core_out ^ r_data;
                w_chain_nx = w_core_out;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cfg_ok  <= 1'b0;
            r_mode    <= MODE_ECB;
            r_key     <= '0;
            r_chain   <= '0;
            r_data    <= '0;
            r_core_in <= '0;
            r_odata   <= '0;
        end else begin
            if (w_cfg) begin
                r_cfg_ok <= 1'b1;
                r_mode   <= i_mode;
                r_key    <= i_key;
                r_chain  <= i_iv;
            end
            if (w_acc) begin
                r_data    <= i_data;
                r_core_in <= w_core_sel;
            end
            if (w_done) begin
                r_odata <= w_result;
                r_chain <= w_chain_nx;
            end
        end
    end

    assign o_data     = r_odata;
    assign w_core_rst = ~i_rst_n;

    AES_Encrypt #(
        .KEY_BITS (KEY_BITS),
        .NR       (NR),
        .NK       (NK)
    ) u_core (
        .i_clk (i_clk),
        .i_rst (w_core_rst),
        .i_vld (w_core_ivld),
        .i_blk (r_core_in),
        .i_key (r_key),
        .o_blk (w_core_out),
        .o_vld (w_core_vld)
    );

endmodule

// File: tb/tb_aes_mode_engine.sv
// Self-checking bench for aes_mode_engine: known-answer vectors,
// CTR wrap, backpressure and asynchronous reset in flight.
module tb_aes_mode_engine;
    import aes_mode_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         cfg_vld = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [127:0] key = '0;
    logic [127:0] iv = '0;
    logic         vld = 1'b0;
    logic         rdy_o;
    logic [127:0] data = '0;
    logic         ovld;
    logic         irdy = 1'b1;
    logic [127:0] odata;
    logic         busy;

    logic         x_cfg_vld = 1'b0;
    logic [1:0]   x_mode = 2'd0;
    logic [191:0] k192 = '0;
    logic [255:0] k256 = '0;
    logic [127:0] x_iv = '0;
    logic         x_vld = 1'b0;
    logic         x_rdy = 1'b0;
    logic [127:0] x_data = '0;
    logic         r192, v192, b192, r256, v256, b256;
    logic [127:0] d192, d256;

    always #5 clk = ~clk;

    aes_mode_engine #(.KEY_BITS(128), .CTR_BITS(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_vld(cfg_vld), .i_mode(mode),
        .i_key(key), .i_iv(iv), .i_vld(vld), .o_rdy(rdy_o), .i_data(data),
        .o_vld(ovld), .i_rdy(irdy), .o_data(odata), .o_busy(busy)
    );

    aes_mode_engine #(.KEY_BITS(192), .CTR_BITS(32)) dut192 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_vld(x_cfg_vld), .i_mode(x_mode),
        .i_key(k192), .i_iv(x_iv), .i_vld(x_vld), .o_rdy(r192), .i_data(x_data),
        .o_vld(v192), .i_rdy(x_rdy), .o_data(d192), .o_busy(b192)
    );

    aes_mode_engine #(.KEY_BITS(256), .CTR_BITS(32)) dut256 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_vld(x_cfg_vld), .i_mode(x_mode),
        .i_key(k256), .i_iv(x_iv), .i_vld(x_vld), .o_rdy(r256), .i_data(x_data),
        .o_vld(v256), .i_rdy(x_rdy), .o_data(d256), .o_busy(b256)
    );

    int n_chk = 0;
    int n_pass = 0;
    int hs_cnt = 0;
    logic [127:0] exp_q[$];
    logic [127:0] mon_exp;
    logic [7:0]   sbt[256];

    typedef struct {
        bit           cfg;
        logic [1:0]   md;
        logic [127:0] k;
        logic [127:0] iv;
        logic [127:0] d;
        logic [127:0] e;
    } vec_t;
    vec_t tv[7];

    localparam logic [127:0] FK  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FP  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] SK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CIV = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        $display("FAIL %s: timed out waiting for the DUT", nm);
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box derived from the GF(2^8) inverse plus affine map.
    task automatic build_sbox();
        logic [7:0] r;
        for (int x = 0; x < 256; x++) begin
            r = 8'h01;
            for (int i = 0; i < 254; i++) r = gm(r, 8'(x));
            sbt[x] = r ^ rl(r, 1) ^ rl(r, 2) ^ rl(r, 3) ^ rl(r, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes128(input logic [127:0] k, input logic [127:0] p);
        logic [7:0] w[176];
        logic [7:0] s[16];
        logic [7:0] t[16];
        logic [7:0] tk[4];
        logic [7:0] rc;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            w[i] = k[127-8*i -: 8];
            s[i] = p[127-8*i -: 8] ^ w[i];
        end
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tk[j] = w[i-4+j];
            if (i % 16 == 0) begin
                tk[0] = sbt[w[i-3]] ^ rc;
                tk[1] = sbt[w[i-2]];
                tk[2] = sbt[w[i-1]];
                tk[3] = sbt[w[i-4]];
                rc = gm(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tk[j];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int q = 0; q < 16; q++)
                t[q] = sbt[s[4*(((q/4)+(q%4))%4)+(q%4)]];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = gm(t[4*c],2) ^ gm(t[4*c+1],3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gm(t[4*c+1],2) ^ gm(t[4*c+2],3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2],2) ^ gm(t[4*c+3],3);
                    s[4*c+3] = gm(t[4*c],3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3],2);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            for (int q = 0; q < 16; q++) s[q] = s[q] ^ w[16*r+q];
        end
        o = '0;
        for (int q = 0; q < 16; q++) o[127-8*q -: 8] = s[q];
        return o;
    endfunction

    always @(negedge clk) begin
        if (rst_n && ovld && irdy) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL result: unexpected o_vld with data %h", odata);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("result", odata, mon_exp);
            end
        end
    end

    task automatic do_cfg(input logic [1:0] md, input logic [127:0] k,
                          input logic [127:0] v);
        @(posedge clk);
        #1;
        cfg_vld = 1'b1;
        mode = md;
        key = k;
        iv = v;
        @(posedge clk);
        #1;
        cfg_vld = 1'b0;
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] e);
        bit done;
        done = 1'b0;
        @(posedge clk);
        #1;
        vld = 1'b1;
        data = d;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (rdy_o) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) timeout("accept");
        @(posedge clk);
        #1;
        vld = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(posedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            timeout("drain");
            exp_q.delete();
        end
    endtask

    initial begin
        logic [127:0] wiv0, wiv1;
        int hs0;
        bit seen;

        build_sbox();
        tv[0] = '{1'b1, MODE_ECB, FK, '0, FP, FC};
        tv[1] = '{1'b1, MODE_CBC, SK, FK, P1, 128'h7649abac8119b246cee98e9b12e9197d};
        tv[2] = '{1'b0, MODE_CBC, SK, FK, P2, 128'h5086cb9b507219ee95db113a917678b2};
        tv[3] = '{1'b1, MODE_CTR, SK, CIV, P1, 128'h874d6191b620e3261bef6864990db6ce};
        tv[4] = '{1'b0, MODE_CTR, SK, CIV, P2, 128'h9806f66b7970fdff8617187bb9fffdff};
        tv[5] = '{1'b1, MODE_OFB, SK, FK, P1, 128'h3b3fd92eb72dad20333449f8e83cfb4a};
        tv[6] = '{1'b0, MODE_OFB, SK, FK, P2, 128'h7789508d16918f03f53c52dac54ed825};

        #1 rst_n = 1'b0;
        #12;
        chk("reset outputs", 128'({rdy_o, ovld, busy}), '0);
        chk("reset o_data", odata, '0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("o_rdy before cfg", 128'(rdy_o), '0);

        for (int i = 0; i < 7; i++) begin
            if (tv[i].cfg) do_cfg(tv[i].md, tv[i].k, tv[i].iv);
            send(tv[i].d, tv[i].e);
            drain();
        end

        // Counter field rolls over; upper 96 bits must be untouched.
        wiv0 = {96'hf0f1f2f3f4f5f6f7f8f9fafb, 32'hffffffff};
        wiv1 = {96'hf0f1f2f3f4f5f6f7f8f9fafb, 32'h00000000};
        do_cfg(MODE_CTR, SK, wiv0);
        send('0, aes128(SK, wiv0));
        drain();
        send('0, aes128(SK, wiv1));
        drain();

        do_cfg(MODE_ECB, FK, '0);
        irdy = 1'b0;
        send(FP, FC);
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            if (ovld) seen = 1'b1;
        end
        if (!seen) timeout("hold o_vld");
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            cfg_vld = (c == 4);
            mode = MODE_CTR;
            iv = CIV;
            @(negedge clk);
            chk("hold o_data", odata, FC);
            chk("hold o_rdy/o_vld", 128'({rdy_o, ovld}), 128'(2'b01));
        end
        hs0 = hs_cnt;
        @(posedge clk);
        #1;
        cfg_vld = 1'b0;
        irdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("after release o_vld/o_rdy", 128'({ovld, rdy_o}), 128'(2'b01));
        chk("handshake count", 128'(hs_cnt - hs0), 128'(1));
        send(FP, FC);
        drain();

        x_mode = MODE_ECB;
        k192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
        k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        @(posedge clk);
        #1 x_cfg_vld = 1'b1;
        @(posedge clk);
        #1;
        x_cfg_vld = 1'b0;
        x_vld = 1'b1;
        x_data = FP;
        @(negedge clk);
        chk("wide keys ready", 128'({r192, r256}), 128'(2'b11));
        @(posedge clk);
        #1 x_vld = 1'b0;
        @(negedge clk);
        chk("wide keys busy", 128'({b192, b256}), 128'(2'b11));
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            if (v192 && v256) seen = 1'b1;
        end
        if (!seen) timeout("wide keys o_vld");
        chk("ECB-192", d192, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        chk("ECB-256", d256, 128'h8ea2b7ca516745bfeafc49904b496089);
        @(posedge clk);
        #1 x_rdy = 1'b1;
        @(posedge clk);
        #1 x_rdy = 1'b0;

        do_cfg(MODE_ECB, FK, '0);
        send(FP, FC);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("mid-run busy/o_vld", 128'({busy, ovld}), 128'(2'b10));
        #2 rst_n = 1'b0;
        #1;
        chk("async reset outputs", 128'({rdy_o, ovld, busy}), '0);
        chk("async reset o_data", odata, '0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        vld = 1'b1;
        data = FP;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("post-reset o_rdy/o_vld", 128'({rdy_o, ovld}), '0);
        end
        @(posedge clk);
        #1 vld = 1'b0;
        do_cfg(MODE_CBC, SK, FK);
        send(P1, 128'h7649abac8119b246cee98e9b12e9197d);
        drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aes_mode_engine.md
# aes_mode_engine

Parametrised AES block-mode engine that drives one iterative AES encryption core (`AES_Encrypt`) to process a stream of 128-bit blocks in ECB, CBC-encrypt, CTR or OFB mode. It owns the key/IV configuration, the chaining/counter register and valid/ready handshakes on both the input and output sides. It sits between the host data path and the cipher core, replacing a single-shot, mode-less core interface.

## Interface

**Parameters**

- `KEY_BITS`, 128, key length in bits: 128, 192 or 256.
- `NK`, `KEY_BITS/32`, key words. Derived localparam.
- `NR`, `NK+6`, round count. Derived localparam.
- `CTR_BITS`, 32, width of the incrementing counter field in the low bits of the chain register (1..128).

**Ports**

- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_cfg_vld`  in  1  configuration load strobe.
- `i_mode`  in  2  mode: 0 ECB, 1 CBC, 2 CTR, 3 OFB.
- `i_key`  in  KEY_BITS  cipher key.
- `i_iv`  in  128  IV or initial counter block.
- `i_vld`  in  1  input block valid.
- `o_rdy`  out  1  engine can accept a block.
- `i_data`  in  128  plaintext block (CTR/OFB: plaintext or ciphertext).
- `o_vld`  out  1  result valid.
- `i_rdy`  in  1  downstream accepts result.
- `o_data`  out  128  result block.
- `o_busy`  out  1  block in flight (RUN or HOLD).

## Operation

- **Registers:** `cfg_ok`, `mode_r`, `key_r`, `chain` (128), `data_r` (128), `core_in` (128), `o_data`.
- **FSM:** IDLE, RUN, HOLD.
- **Configuration:** `i_cfg_vld` in IDLE latches `mode_r`, `key_r` and `chain <= i_iv`, and sets `cfg_ok`. In RUN/HOLD it is ignored. Reconfiguration between blocks restarts chaining from the new IV.
- **Ready:** `o_rdy = (state==IDLE) & cfg_ok & ~i_cfg_vld`. Configuration wins over data in the same cycle.
- **Accept** (`i_vld & o_rdy`): latch `data_r <= i_data` and `core_in`, then go to RUN.
  - ECB: `core_in = i_data`.
  - CBC: `core_in = i_data ^ chain`.
  - CTR/OFB: `core_in = chain`.
- **RUN:** core `i_vld` is held high and `core_in`/`key_r` are held stable. On core `o_vld`, register the result and go to HOLD; core `i_vld` drops in the same cycle.
  - ECB: `o_data = core_out`.
  - CBC: `o_data = core_out`; `chain <= core_out`.
  - CTR: `o_data = core_out ^ data_r`; `chain[CTR_BITS-1:0] += 1` modulo 2^CTR_BITS; upper bits unchanged.
  - OFB: `o_data = core_out ^ data_r`; `chain <= core_out`.
- **HOLD:** `o_vld=1` and `o_data` stays stable until `i_rdy`, then go to IDLE. `i_rdy` outside HOLD has no effect.
- Core `o_vld` outside RUN is ignored.
- **Reset** (async, any state, including mid-block): state IDLE; `o_rdy=0`, `o_vld=0`, `o_busy=0`, `o_data=0`; `cfg_ok=0`, `chain=0`. The core is reset via `~i_rst_n`. The in-flight block is discarded.

## Timing

- Accept edge t: `core_in` registered; core `i_vld` high from cycle t+1.
- Core reports `o_vld` L cycles later, where L is the core latency. `o_vld` rises on the cycle after core `o_vld` is sampled.
- Accept-to-`o_vld`: L+2 cycles.
- Throughput: one block per L+3 cycles when `i_rdy` is held high. There is no overlap, because IDLE is the only accepting state.
- `o_rdy` is low from the accept edge until the cycle after the `o_vld & i_rdy` handshake.
- CTR counter update is visible to the next accepted block; no bubble beyond the FSM.

## Structure

- Package `aes_mode_pkg`:
  - mode encodings `MODE_ECB/CBC/CTR/OFB`;
  - FSM state typedef;
  - `AES_BLK = 128`;
  - function `nr_of(key_bits)`.
- One sub-module: `AES_Encrypt` instantiated with (`KEY_BITS`, `NR`, `NK`). Its ports are clock, active-high reset, in valid, in block, key, out block, out valid.
- Chaining, counter and XOR logic stay in the top module.

## Test plan

- **AES-128 ECB** (FIPS-197): key 000102…0f, data 00112233445566778899aabbccddeeff → o_data 69c4e0d86a7b0430d8cdb78070b4c55a. Repeat with KEY_BITS=192 (key 00…17) → dda97ca4864cdfe06eaf70a0ec0d7191, and KEY_BITS=256 (key 00…1f) → 8ea2b7ca516745bfeafc49904b496089.
- **CBC** (SP800-38A): key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102…0f.
  - 6bc1bee22e409f96e93d7e117393172a → 7649abac8119b246cee98e9b12e9197d.
  - ae2d8a571e03ac9c9eb76fac45af8e51 → 5086cb9b507219ee95db113a917678b2.
- **CTR** and **OFB**, same key, same two plaintexts:
  - CTR, IV f0f1…feff → 874d6191b620e3261bef6864990db6ce, 9806f66b7970fdff8617187bb9fffdff.
  - OFB, IV 000102…0f → 3b3fd92eb72dad20333449f8e83cfb4a, 7789508d16918f03f53c52dac54ed825.
- **CTR wrap:** IV low 32 bits ffffffff, two zero blocks. Second output must equal the ECB of the IV with low 32 bits 00000000 and upper 96 bits unchanged.
- **Backpressure:** hold `i_rdy=0` for 10 cycles in HOLD. `o_data` must stay stable, `o_rdy` must stay 0, and a `i_cfg_vld` pulse is ignored. On release, one handshake occurs, then return to IDLE.
- **Reset mid-RUN:** assert `i_rst_n=0` asynchronously. All outputs must go to 0 immediately and `cfg_ok` must clear. After release, `o_rdy` stays 0 until reconfiguration, and no stale `o_vld` appears.
